// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM channel arbiters.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_t;

    localparam int unsigned TimeoutW = 8;

    // ptr < n and k < n, so a single conditional subtract implements the wraparound.
    function automatic logic [2:0] rr_pick(input logic [7:0] pend, input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [2:0] win;
        logic       found;
        logic [3:0] idx;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if ((4'(k) < n) && !found && pend[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sdram_ch2_arb_if.sv
// Master-side and SDRAM-side signal bundle of the channel-2 arbiter.
interface sdram_ch2_arb_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0][25:0] m_addr;
    logic [NUM_REQ-1:0][31:0] m_din;
    logic [NUM_REQ-1:0]       m_rnw;
    logic [NUM_REQ-1:0]       m_req;
    logic [31:0]              m_dout;
    logic [NUM_REQ-1:0]       m_ready;
    logic [25:0]              sd_addr;
    logic [31:0]              sd_din;
    logic                     sd_rnw;
    logic                     sd_req;
    logic [31:0]              sd_dout;
    logic                     sd_ready;
    logic [2:0]               grant_id;
    logic                     busy;
    logic                     timeout_err;

    modport slave (
        input  m_addr, m_din, m_rnw, m_req, sd_dout, sd_ready,
        output m_dout, m_ready, sd_addr, sd_din, sd_rnw, sd_req, grant_id, busy, timeout_err
    );

    modport master (
        output m_addr, m_din, m_rnw, m_req, sd_dout, sd_ready,
        input  m_dout, m_ready, sd_addr, sd_din, sd_rnw, sd_req, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin priority encoder: first set bit at or above i_ptr, wrapping.
module sdram_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_pend,
    input  logic [2:0]         i_ptr,
    output logic [2:0]         o_win,
    output logic               o_any
);
    logic [7:0] w_pend8;

    always_comb begin
        w_pend8                = '0;
        w_pend8[NUM_REQ-1:0]   = i_pend;
    end

    assign o_win = rr_pick(w_pend8, i_ptr, 4'(NUM_REQ));
    assign o_any = |i_pend;
endmodule

// File: rtl/sdram_ch2_arb.sv
// Channel-2 SDRAM arbiter: latches master requests and keeps one transaction outstanding,
// holding address/data/direction stable until the SDRAM ready pulse or a timeout.
module sdram_ch2_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter bit          PRIO0   = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clk,
    input logic            init,
    sdram_ch2_arb_if.slave bus
);
    localparam logic [NUM_REQ-1:0]  ReqOne   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [TimeoutW-1:0] TcntLast = TimeoutW'(TIMEOUT - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_pend, w_pend_nxt;
    logic [2:0]          r_rr_ptr, r_grant;
    logic                r_prio_win;
    logic [TimeoutW-1:0] r_tcnt;
    logic                r_timed_out;
    logic [25:0]         r_sd_addr;
    logic [31:0]         r_sd_din;
    logic                r_sd_rnw;
    logic [31:0]         r_m_dout;

    logic [2:0]          w_rr_win, w_win;
    logic                w_any, w_prio, w_grant_now;
    logic                w_sd_req, w_busy, w_timeout_err;
    logic [NUM_REQ-1:0]  w_m_ready, w_clr;
    logic [25:0]         w_sel_addr;
    logic [31:0]         w_sel_din;
    logic                w_sel_rnw;

    sdram_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_pend (r_pend),
        .i_ptr  (r_rr_ptr),
        .o_win  (w_rr_win),
        .o_any  (w_any)
    );

    assign w_prio = PRIO0 && r_pend[0];
    assign w_win  = w_prio ? 3'd0 : w_rr_win;

    always_comb begin
        w_sel_addr = '0;
        w_sel_din  = '0;
        w_sel_rnw  = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win == 3'(i)) begin
                w_sel_addr = bus.m_addr[i];
                w_sel_din  = bus.m_din[i];
                w_sel_rnw  = bus.m_rnw[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_now   = 1'b0;
        w_sd_req      = 1'b0;
        w_busy        = 1'b0;
        w_m_ready     = '0;
        w_timeout_err = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_grant_now = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_sd_req    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = StWait;
            end
            StWait: begin
                w_busy = 1'b1;
                if (bus.sd_ready || (r_tcnt == TcntLast)) w_state_nxt = StDone;
            end
            StDone: begin
                if (r_timed_out) w_timeout_err = 1'b1;
                else             w_m_ready     = ReqOne << r_grant;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // A request arriving in its own grant cycle survives the clear as a fresh pending bit.
    assign w_clr      = w_grant_now ? (ReqOne << w_win) : '0;
    assign w_pend_nxt = (r_pend & ~w_clr) | bus.m_req;

    always_ff @(posedge clk) begin
        if (init) begin
            r_state     <= StIdle;
            r_pend      <= '0;
            r_rr_ptr    <= 3'd0;
            r_grant     <= 3'd0;
            r_prio_win  <= 1'b0;
            r_tcnt      <= '0;
            r_timed_out <= 1'b0;
            r_sd_addr   <= '0;
            r_sd_din    <= '0;
            r_sd_rnw    <= 1'b1;
            r_m_dout    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_grant_now) begin
                r_sd_addr  <= w_sel_addr;
                r_sd_din   <= w_sel_din;
                r_sd_rnw   <= w_sel_rnw;
                r_grant    <= w_win;
                r_prio_win <= w_prio;
            end
            if (r_state == StIssue) begin
                r_tcnt      <= '0;
                r_timed_out <= 1'b0;
            end else if (r_state == StWait) begin
                r_tcnt <= r_tcnt + 1'b1;
                if (bus.sd_ready) begin
                    if (r_sd_rnw) r_m_dout <= bus.sd_dout;
                end else if (r_tcnt == TcntLast) begin
                    r_timed_out <= 1'b1;
                end
            end
            if ((r_state == StDone) && !r_prio_win) begin
                r_rr_ptr <= (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
            end
        end
    end

    assign bus.sd_addr     = r_sd_addr;
    assign bus.sd_din      = r_sd_din;
    assign bus.sd_rnw      = r_sd_rnw;
    assign bus.sd_req      = w_sd_req;
    assign bus.m_dout      = r_m_dout;
    assign bus.m_ready     = w_m_ready;
    assign bus.grant_id    = r_grant;
    assign bus.busy        = w_busy;
    assign bus.timeout_err = w_timeout_err;
endmodule

// File: tb/tb_sdram_ch2_arb.sv
// Directed bench: two arbiters (PRIO0=1 and PRIO0=0) driven identically, each with an SDRAM model.
module tb_sdram_ch2_arb;
    localparam int unsigned TbTimeout = 255;

    logic clk;
    logic init;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    int          mdl_lat = 6;
    bit          mdl_never = 1'b0;
    bit          mdl_xor = 1'b0;
    logic [31:0] mdl_data = 32'h0;
    int          cnt0 = 0;
    int          cnt1 = 0;

    int          g_log0[$];
    int          g_log1[$];
    logic [25:0] ra_log[$];
    logic [31:0] rd_log[$];
    logic        rw_log[$];
    logic [3:0]  rdy_log[$];
    logic [31:0] dout_log[$];
    int          req_cyc, rdy_cyc, to_cyc, t_req;
    int          n_rdy = 0, n_sdreq = 0, n_to = 0, seq_viol = 0, hold_viol = 0;
    bit          outstanding = 1'b0;
    logic [25:0] hold_addr;
    logic [31:0] hold_din;
    int          snap_rdy, snap_req, snap_to;

    sdram_ch2_arb_if #(.NUM_REQ(4)) if0 ();
    sdram_ch2_arb_if #(.NUM_REQ(4)) if1 ();

    sdram_ch2_arb #(.NUM_REQ(4), .PRIO0(1'b1), .TIMEOUT(TbTimeout)) u_dut0 (
        .clk  (clk),
        .init (init),
        .bus  (if0)
    );

    sdram_ch2_arb #(.NUM_REQ(4), .PRIO0(1'b0), .TIMEOUT(TbTimeout)) u_dut1 (
        .clk  (clk),
        .init (init),
        .bus  (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM models: sd_ready mdl_lat cycles after the sd_req cycle.
    initial begin
        if0.sd_ready = 1'b0;
        if0.sd_dout  = '0;
        forever begin
            @(negedge clk);
            if0.sd_ready = 1'b0;
            if (if0.sd_req && !mdl_never) cnt0 = mdl_lat;
            else if (cnt0 > 0) begin
                cnt0--;
                if (cnt0 == 0) begin
                    if0.sd_ready = 1'b1;
                    if0.sd_dout  = mdl_xor ? ({6'b0, if0.sd_addr} ^ 32'h5A5A_0000) : mdl_data;
                end
            end
        end
    end

    initial begin
        if1.sd_ready = 1'b0;
        if1.sd_dout  = '0;
        forever begin
            @(negedge clk);
            if1.sd_ready = 1'b0;
            if (if1.sd_req && !mdl_never) cnt1 = mdl_lat;
            else if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) begin
                    if1.sd_ready = 1'b1;
                    if1.sd_dout  = mdl_xor ? ({6'b0, if1.sd_addr} ^ 32'h5A5A_0000) : mdl_data;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (init) begin
                outstanding = 1'b0;
            end else begin
                if (if0.sd_req) begin
                    if (outstanding) seq_viol++;
                    outstanding = 1'b1;
                    n_sdreq++;
                    req_cyc   = cyc;
                    hold_addr = if0.sd_addr;
                    hold_din  = if0.sd_din;
                    g_log0.push_back(int'(if0.grant_id));
                    ra_log.push_back(if0.sd_addr);
                    rd_log.push_back(if0.sd_din);
                    rw_log.push_back(if0.sd_rnw);
                end else if (outstanding && (if0.sd_addr != hold_addr || if0.sd_din != hold_din)) begin
                    hold_viol++;
                end
                if (if0.m_ready != 0) begin
                    n_rdy++;
                    rdy_cyc = cyc;
                    rdy_log.push_back(if0.m_ready);
                    dout_log.push_back(if0.m_dout);
                    outstanding = 1'b0;
                end
                if (if0.timeout_err) begin
                    n_to++;
                    to_cyc      = cyc;
                    outstanding = 1'b0;
                end
                if (if1.sd_req) g_log1.push_back(int'(if1.grant_id));
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_master(input int i, input logic [25:0] a, input logic [31:0] d,
                              input logic rnw);
        if0.m_addr[i] = a; if0.m_din[i] = d; if0.m_rnw[i] = rnw;
        if1.m_addr[i] = a; if1.m_din[i] = d; if1.m_rnw[i] = rnw;
    endtask

    task automatic pulse_req(input logic [3:0] mask);
        @(negedge clk);
        if0.m_req = mask;
        if1.m_req = mask;
        t_req     = cyc;
        @(negedge clk);
        if0.m_req = '0;
        if1.m_req = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if0.m_ready == 0 && !if0.timeout_err && n < 400);
        check_eq({tag, " in bound"}, 64'(n < 400), 64'd1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
    endtask

    task automatic clear_logs();
        g_log0.delete(); g_log1.delete(); ra_log.delete(); rd_log.delete();
        rw_log.delete(); rdy_log.delete(); dout_log.delete();
    endtask

    initial begin
        init = 1'b1;
        if0.m_addr = '0; if0.m_din = '0; if0.m_rnw = '1; if0.m_req = '0;
        if1.m_addr = '0; if1.m_din = '0; if1.m_rnw = '1; if1.m_req = '0;
        repeat (3) @(negedge clk);
        check_eq("rst busy", 64'(if0.busy), 64'd0);
        check_eq("rst sd_req", 64'(if0.sd_req), 64'd0);
        check_eq("rst m_ready", 64'(if0.m_ready), 64'd0);
        check_eq("rst timeout_err", 64'(if0.timeout_err), 64'd0);
        check_eq("rst grant_id", 64'(if0.grant_id), 64'd0);
        check_eq("rst sd_addr", 64'(if0.sd_addr), 64'd0);
        check_eq("rst sd_din", 64'(if0.sd_din), 64'd0);
        check_eq("rst m_dout", 64'(if0.m_dout), 64'd0);
        check_eq("rst sd_rnw", 64'(if0.sd_rnw), 64'd1);
        init = 1'b0;

        // Single read from master 2.
        mdl_xor = 1'b0; mdl_data = 32'hDEAD_BEEF; mdl_lat = 6;
        set_master(2, 26'h012_3456, 32'h0, 1'b1);
        clear_logs();
        pulse_req(4'b0100);
        wait_done("t1");
        check_eq("t1 m_ready", 64'(if0.m_ready), 64'h4);
        check_eq("t1 m_dout", 64'(if0.m_dout), 64'hDEAD_BEEF);
        check_eq("t1 grant_id", 64'(if0.grant_id), 64'd2);
        check_eq("t1 latency", 64'(rdy_cyc - t_req), 64'd9);
        check_eq("t1 sd_req count", 64'(g_log0.size()), 64'd1);
        if (ra_log.size() > 0) begin
            check_eq("t1 sd_addr", 64'(ra_log[0]), 64'h012_3456);
            check_eq("t1 sd_rnw", 64'(rw_log[0]), 64'd1);
        end
        @(negedge clk);
        check_eq("t1 ready pulse width", 64'(if0.m_ready), 64'd0);

        // Simultaneous requests from masters 1..3 after a fresh reset.
        do_reset();
        mdl_xor = 1'b1;
        for (int i = 0; i < 4; i++) set_master(i, 26'h100 + 26'(i), 32'h0, 1'b1);
        clear_logs();
        pulse_req(4'b1110);
        for (int k = 0; k < 3; k++) wait_done("t2");
        check_eq("t2 grants", 64'(g_log0.size()), 64'd3);
        check_eq("t2 readies", 64'(rdy_log.size()), 64'd3);
        for (int k = 0; k < 3 && k < g_log0.size() && k < rdy_log.size(); k++) begin
            check_eq($sformatf("t2 grant[%0d]", k), 64'(g_log0[k]), 64'(k + 1));
            check_eq($sformatf("t2 ready[%0d]", k), 64'(rdy_log[k]), 64'(4'b0010 << k));
            check_eq($sformatf("t2 dout[%0d]", k), 64'(dout_log[k]), 64'(32'h5A5A_0101 + k));
        end
        check_eq("t2 sd_req while busy", 64'(seq_viol), 64'd0);

        // Preemption while master 1 waits on the SDRAM.
        clear_logs();
        pulse_req(4'b0010);
        repeat (2) @(negedge clk);
        check_eq("t3 busy in wait", 64'(if0.busy), 64'd1);
        pulse_req(4'b1001);
        for (int k = 0; k < 3; k++) wait_done("t3");
        repeat (2) @(negedge clk);
        check_eq("t3 prio grants", 64'(g_log0.size()), 64'd3);
        check_eq("t3 rr grants", 64'(g_log1.size()), 64'd3);
        if (g_log0.size() == 3 && g_log1.size() == 3) begin
            check_eq("t3 prio order", 64'({g_log0[0][3:0], g_log0[1][3:0], g_log0[2][3:0]}),
                     64'h103);
            check_eq("t3 rr order", 64'({g_log1[0][3:0], g_log1[1][3:0], g_log1[2][3:0]}),
                     64'h130);
        end
        check_eq("t3 last dout", 64'(if0.m_dout), 64'h5A5A_0103);

        // Write with slow SDRAM: bus must stay frozen, m_dout untouched.
        mdl_lat = 20;
        set_master(1, 26'h1AB_CDEF, 32'hCAFE_F00D, 1'b0);
        clear_logs();
        hold_viol = 0;
        pulse_req(4'b0010);
        wait_done("t4");
        check_eq("t4 m_ready", 64'(if0.m_ready), 64'h2);
        check_eq("t4 m_dout kept", 64'(if0.m_dout), 64'h5A5A_0103);
        check_eq("t4 latency", 64'(rdy_cyc - t_req), 64'd23);
        check_eq("t4 hold", 64'(hold_viol), 64'd0);
        if (ra_log.size() > 0) begin
            check_eq("t4 sd_din", 64'(rd_log[0]), 64'hCAFE_F00D);
            check_eq("t4 sd_addr", 64'(ra_log[0]), 64'h1AB_CDEF);
            check_eq("t4 sd_rnw", 64'(rw_log[0]), 64'd0);
        end

        // Timeout, then a normal transaction.
        mdl_never = 1'b1;
        set_master(2, 26'h102, 32'h0, 1'b1);
        snap_rdy = n_rdy;
        pulse_req(4'b0100);
        wait_done("t5");
        check_eq("t5 timeout_err", 64'(if0.timeout_err), 64'd1);
        check_eq("t5 timeout delay", 64'(to_cyc - req_cyc), 64'(TbTimeout + 1));
        check_eq("t5 no m_ready", 64'(n_rdy - snap_rdy), 64'd0);
        check_eq("t5 m_dout kept", 64'(if0.m_dout), 64'h5A5A_0103);
        @(negedge clk);
        check_eq("t5 idle busy", 64'(if0.busy), 64'd0);
        check_eq("t5 err pulse width", 64'(if0.timeout_err), 64'd0);
        mdl_never = 1'b0;
        mdl_lat   = 3;
        pulse_req(4'b0100);
        wait_done("t5b");
        check_eq("t5b m_ready", 64'(if0.m_ready), 64'h4);
        check_eq("t5b m_dout", 64'(if0.m_dout), 64'h5A5A_0102);
        check_eq("t5b latency", 64'(rdy_cyc - t_req), 64'd6);

        // Reset during WAIT, with a request in the same cycle as init.
        mdl_lat = 6;
        set_master(3, 26'h103, 32'h0, 1'b1);
        pulse_req(4'b1000);
        repeat (2) @(negedge clk);
        check_eq("t6 busy before init", 64'(if0.busy), 64'd1);
        snap_rdy = n_rdy;
        snap_req = n_sdreq;
        snap_to  = n_to;
        @(negedge clk);
        init = 1'b1;
        if0.m_req = 4'b0010;
        if1.m_req = 4'b0010;
        @(negedge clk);
        init = 1'b0;
        if0.m_req = '0;
        if1.m_req = '0;
        check_eq("t6 busy after init", 64'(if0.busy), 64'd0);
        check_eq("t6 grant_id", 64'(if0.grant_id), 64'd0);
        repeat (20) @(negedge clk);
        check_eq("t6 no m_ready", 64'(n_rdy - snap_rdy), 64'd0);
        check_eq("t6 dropped req", 64'(n_sdreq - snap_req), 64'd0);
        check_eq("t6 no timeout", 64'(n_to - snap_to), 64'd0);
        check_eq("t6 idle", 64'(if0.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
